// File: rtl/map_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// map_fetch_arbiter
//
// Purpose:
//   Shares the single-port 128x128x2b map RAM between the video pixel pipeline
//   and the game-logic (cpu) requester. Video requests translate a pixel
//   coordinate into a map cell, read its 2-bit value and hand it to the map
//   colorizer together with the echoed pixel coordinates. The cpu side gets
//   whatever RAM slots video leaves free through a req/ack handshake. Video
//   always wins arbitration and only one RAM access is in flight at a time.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   video_req            1-cycle pulse per pixel tick, pixel_row/column valid
//   pixel_row/column     12-bit pixel coordinates from the timing generator
//   video_valid          1-cycle pulse, map_value/out_of_map/pix_*_q valid
//   map_value            cell value for the colorizer (00 when out_of_map)
//   out_of_map           pixel lies outside the map
//   pix_row_q/pix_col_q  pixel coordinates echoed, aligned with map_value
//   cpu_req/cpu_addr     level request with {row,col} cell address
//   cpu_ack/cpu_rdata    1-cycle acknowledge with the read value
//   map_addr/map_rd_en   registered RAM address and read enable
//   map_data             RAM read data, valid RD_LATENCY cycles after address
//   video_overrun        sticky flag, a video request was overwritten
// -----------------------------------------------------------------------------
module map_fetch_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int CELL_LOG2  = 2,
  parameter int MAP_LOG2   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  video_req,
  input  logic [11:0]           pixel_row,
  input  logic [11:0]           pixel_column,
  output logic                  video_valid,
  output logic [1:0]            map_value,
  output logic                  out_of_map,
  output logic [11:0]           pix_row_q,
  output logic [11:0]           pix_col_q,
  input  logic                  cpu_req,
  input  logic [2*MAP_LOG2-1:0] cpu_addr,
  output logic                  cpu_ack,
  output logic [1:0]            cpu_rdata,
  output logic [2*MAP_LOG2-1:0] map_addr,
  output logic                  map_rd_en,
  input  logic [1:0]            map_data,
  output logic                  video_overrun
);

  localparam int ADDR_W = 2 * MAP_LOG2;
  localparam int CNT_W  = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] RD_LAT_C  = CNT_W'(RD_LATENCY);
  localparam logic [11:0]      MAP_CELLS = 12'(2 ** MAP_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_V,
    BUSY_C
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vid_pend_q, vid_pend_d;
  logic [11:0]       pend_row_q, pend_row_d;
  logic [11:0]       pend_col_q, pend_col_d;
  logic [11:0]       cur_row_q, cur_row_d;
  logic [11:0]       cur_col_q, cur_col_d;
  logic              cur_oob_q, cur_oob_d;
  logic              cpu_inflight_q, cpu_inflight_d;
  logic              video_valid_q, video_valid_d;
  logic [1:0]        map_value_q, map_value_d;
  logic              out_of_map_q, out_of_map_d;
  logic [11:0]       echo_row_q, echo_row_d;
  logic [11:0]       echo_col_q, echo_col_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [1:0]        cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] map_addr_q, map_addr_d;
  logic              map_rd_en_q, map_rd_en_d;
  logic              overrun_q, overrun_d;

  logic        slot_free;
  logic        vid_avail;
  logic        issue_vid;
  logic        issue_cpu;
  logic        capture_v;
  logic        capture_c;
  logic [11:0] sel_row, sel_col;
  logic [11:0] sel_rc, sel_cc;
  logic        sel_oob;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and arbitration. A slot frees up either in IDLE or on the
  // capture edge of the current access, which lets the next request issue
  // back-to-back without an idle cycle.
  always_comb begin
    slot_free = (state_q == IDLE) || (cnt_q == '0);
    vid_avail = vid_pend_q || video_req;
    issue_vid = slot_free && vid_avail;
    issue_cpu = slot_free && !vid_avail && cpu_req && !cpu_inflight_q;
    state_d   = state_q;
    if (issue_vid) begin
      state_d = BUSY_V;
    end else if (issue_cpu) begin
      state_d = BUSY_C;
    end else if (slot_free) begin
      state_d = IDLE;
    end
  end

  // Datapath next values. The older pending video request is issued ahead of
  // a request arriving the same edge; the newcomer then becomes pending.
  always_comb begin
    capture_v = (state_q == BUSY_V) && (cnt_q == '0);
    capture_c = (state_q == BUSY_C) && (cnt_q == '0);

    sel_row = vid_pend_q ? pend_row_q : pixel_row;
    sel_col = vid_pend_q ? pend_col_q : pixel_column;
    sel_rc  = sel_row >> CELL_LOG2;
    sel_cc  = sel_col >> CELL_LOG2;
    sel_oob = (sel_rc >= MAP_CELLS) || (sel_cc >= MAP_CELLS);

    vid_pend_d     = vid_pend_q;
    pend_row_d     = pend_row_q;
    pend_col_d     = pend_col_q;
    cur_row_d      = cur_row_q;
    cur_col_d      = cur_col_q;
    cur_oob_d      = cur_oob_q;
    cnt_d          = cnt_q;
    cpu_inflight_d = cpu_inflight_q;
    map_addr_d     = map_addr_q;
    map_rd_en_d    = 1'b0;
    overrun_d      = overrun_q;
    video_valid_d  = capture_v;
    map_value_d    = map_value_q;
    out_of_map_d   = out_of_map_q;
    echo_row_d     = echo_row_q;
    echo_col_d     = echo_col_q;
    cpu_ack_d      = capture_c;
    cpu_rdata_d    = cpu_rdata_q;

    if (issue_vid) begin
      vid_pend_d = vid_pend_q && video_req;
    end else begin
      vid_pend_d = vid_pend_q || video_req;
    end

    // A live request goes straight to the RAM when nothing is pending;
    // otherwise it is parked, replacing any pending one that did not issue.
    if (video_req && !(issue_vid && !vid_pend_q)) begin
      pend_row_d = pixel_row;
      pend_col_d = pixel_column;
    end
    if (video_req && vid_pend_q && !issue_vid) begin
      overrun_d = 1'b1;
    end

    if (issue_vid) begin
      cur_row_d   = sel_row;
      cur_col_d   = sel_col;
      cur_oob_d   = sel_oob;
      map_addr_d  = {sel_rc[MAP_LOG2-1:0], sel_cc[MAP_LOG2-1:0]};
      map_rd_en_d = !sel_oob;
    end else if (issue_cpu) begin
      map_addr_d  = cpu_addr;
      map_rd_en_d = 1'b1;
    end

    if (issue_vid || issue_cpu) begin
      cnt_d = RD_LAT_C;
    end else if ((state_q != IDLE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // The in-flight flag stays up past the ack until cpu_req is seen low, so
    // a request still held after its ack is not served twice.
    if (issue_cpu) begin
      cpu_inflight_d = 1'b1;
    end else if (!cpu_req) begin
      cpu_inflight_d = 1'b0;
    end

    if (capture_v) begin
      map_value_d  = cur_oob_q ? 2'b00 : map_data;
      out_of_map_d = cur_oob_q;
      echo_row_d   = cur_row_q;
      echo_col_d   = cur_col_q;
    end
    if (capture_c) begin
      cpu_rdata_d = map_data;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      vid_pend_q     <= 1'b0;
      pend_row_q     <= '0;
      pend_col_q     <= '0;
      cur_row_q      <= '0;
      cur_col_q      <= '0;
      cur_oob_q      <= 1'b0;
      cpu_inflight_q <= 1'b0;
      map_addr_q     <= '0;
      map_rd_en_q    <= 1'b0;
      overrun_q      <= 1'b0;
      video_valid_q  <= 1'b0;
      map_value_q    <= '0;
      out_of_map_q   <= 1'b0;
      echo_row_q     <= '0;
      echo_col_q     <= '0;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
    end else begin
      cnt_q          <= cnt_d;
      vid_pend_q     <= vid_pend_d;
      pend_row_q     <= pend_row_d;
      pend_col_q     <= pend_col_d;
      cur_row_q      <= cur_row_d;
      cur_col_q      <= cur_col_d;
      cur_oob_q      <= cur_oob_d;
      cpu_inflight_q <= cpu_inflight_d;
      map_addr_q     <= map_addr_d;
      map_rd_en_q    <= map_rd_en_d;
      overrun_q      <= overrun_d;
      video_valid_q  <= video_valid_d;
      map_value_q    <= map_value_d;
      out_of_map_q   <= out_of_map_d;
      echo_row_q     <= echo_row_d;
      echo_col_q     <= echo_col_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
    end
  end

  // Output drive
  always_comb begin
    video_valid   = video_valid_q;
    map_value     = map_value_q;
    out_of_map    = out_of_map_q;
    pix_row_q     = echo_row_q;
    pix_col_q     = echo_col_q;
    cpu_ack       = cpu_ack_q;
    cpu_rdata     = cpu_rdata_q;
    map_addr      = map_addr_q;
    map_rd_en     = map_rd_en_q;
    video_overrun = overrun_q;
  end

endmodule
